// File: rtl/elevator_car_responder_pkg.sv
// Shared elevator definitions: car/door state encodings, door_state codes and sizing helpers.
package elevator_car_responder_pkg;

  localparam int unsigned NumFloorsDefault = 11;
  localparam int unsigned FloorW           = 4;

  typedef enum logic [1:0] {
    CarIdle   = 2'b00,
    CarUp     = 2'b01,
    CarDown   = 2'b10,
    CarHalted = 2'b11
  } car_state_e;

  // Values double as the external door_state codes.
  typedef enum logic [1:0] {
    DoorClosed  = 2'b00,
    DoorOpening = 2'b01,
    DoorOpen    = 2'b10,
    DoorClosing = 2'b11
  } door_state_e;

  function automatic int unsigned cnt_width(int unsigned limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/elevator_door_actuator.sv
// Door stroke FSM: timed open/close strokes with position-continuous reversal while closing.
module elevator_door_actuator
  import elevator_car_responder_pkg::*;
#(
  parameter int unsigned DOOR_TRAVEL_CYCLES = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        open_cmd_i,
  input  logic        close_cmd_i,
  input  logic        power_on_i,
  input  logic        open_allow_i,
  output door_state_e state_o
);

  localparam int unsigned     CntW   = cnt_width(DOOR_TRAVEL_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DOOR_TRAVEL_CYCLES - 1);

  door_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    // Without power the door neither accepts commands nor moves.
    if (power_on_i) begin
      case (state_q)
        DoorClosed: begin
          if (open_cmd_i && open_allow_i) begin
            state_d = DoorOpening;
            cnt_d   = '0;
          end
        end
        DoorOpening: begin
          if (cnt_q == CntMax) begin
            state_d = DoorOpen;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        DoorOpen: begin
          if (close_cmd_i && !open_cmd_i) begin
            state_d = DoorClosing;
            cnt_d   = '0;
          end
        end
        DoorClosing: begin
          if (open_cmd_i) begin
            state_d = DoorOpening;
            cnt_d   = CntMax - cnt_q;
          end else if (cnt_q == CntMax) begin
            state_d = DoorClosed;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: state_d = DoorClosed;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= DoorClosed;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/elevator_car_responder.sv
// Elevator car responder: car travel FSM with halt/resume and command interlocks, plus door actuator.
module elevator_car_responder
  import elevator_car_responder_pkg::*;
#(
  parameter int unsigned NUM_FLOORS          = NumFloorsDefault,
  parameter int unsigned FLOOR_TRAVEL_CYCLES = 16,
  parameter int unsigned DOOR_TRAVEL_CYCLES  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              move_up,
  input  logic              move_down,
  input  logic              door_open_cmd,
  input  logic              door_close_cmd,
  input  logic              emergency_stop,
  input  logic              power_on,
  output logic [FloorW-1:0] current_floor,
  output logic              at_floor_pulse,
  output logic              car_moving,
  output logic              car_direction,
  output logic [1:0]        door_state,
  output logic              interlock_fault
);

  localparam int unsigned       CntW     = cnt_width(FLOOR_TRAVEL_CYCLES);
  localparam logic [CntW-1:0]   CntMax   = CntW'(FLOOR_TRAVEL_CYCLES - 1);
  localparam logic [FloorW-1:0] FloorTop = FloorW'(NUM_FLOORS - 1);

  car_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [FloorW-1:0] floor_q, floor_d;
  logic              dir_q, dir_d;
  logic              resume_q, resume_d;
  logic              moving_q, moving_d;
  logic              pulse_q, pulse_d;
  logic              fault_q, fault_d;
  door_state_e       door_q;
  logic              halt, door_closed, door_allow;

  assign halt        = emergency_stop || !power_on;
  assign door_closed = (door_q == DoorClosed);
  // Door may only open while the car sits exactly at a floor.
  assign door_allow  = (state_q == CarIdle) || ((state_q == CarHalted) && (cnt_q == '0));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    floor_d  = floor_q;
    dir_d    = dir_q;
    resume_d = resume_q;
    pulse_d  = 1'b0;
    fault_d  = door_open_cmd && ((state_q == CarUp) || (state_q == CarDown));
    case (state_q)
      CarIdle: begin
        resume_d = 1'b0;
        if (halt) begin
          state_d = CarHalted;
        end else if (move_up || move_down) begin
          if ((move_up && move_down) || !door_closed || (move_up && (floor_q == FloorTop)) ||
              (move_down && (floor_q == '0))) begin
            fault_d = 1'b1;
          end else if (!door_open_cmd) begin
            // A simultaneous door open request takes precedence over starting travel.
            state_d = move_up ? CarUp : CarDown;
            dir_d   = move_up;
            cnt_d   = '0;
          end
        end
      end
      CarUp: begin
        if (halt) begin
          state_d  = CarHalted;
          resume_d = 1'b1;
        end else if (cnt_q == CntMax) begin
          pulse_d = 1'b1;
          cnt_d   = '0;
          floor_d = floor_q + FloorW'(1);
          if (!move_up || (floor_d == FloorTop)) state_d = CarIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      CarDown: begin
        if (halt) begin
          state_d  = CarHalted;
          resume_d = 1'b1;
        end else if (cnt_q == CntMax) begin
          pulse_d = 1'b1;
          cnt_d   = '0;
          floor_d = floor_q - FloorW'(1);
          if (!move_down || (floor_d == '0)) state_d = CarIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      CarHalted: begin
        // An open door during the halt (only possible at count 0) cancels the resume.
        if (!halt) begin
          if (resume_q && door_closed) state_d = dir_q ? CarUp : CarDown;
          else                         state_d = CarIdle;
        end
      end
      default: state_d = CarIdle;
    endcase
    moving_d = (state_d == CarUp) || (state_d == CarDown);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= CarIdle;
      cnt_q    <= '0;
      floor_q  <= '0;
      dir_q    <= 1'b1;
      resume_q <= 1'b0;
      moving_q <= 1'b0;
      pulse_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      floor_q  <= floor_d;
      dir_q    <= dir_d;
      resume_q <= resume_d;
      moving_q <= moving_d;
      pulse_q  <= pulse_d;
      fault_q  <= fault_d;
    end
  end

  elevator_door_actuator #(
    .DOOR_TRAVEL_CYCLES(DOOR_TRAVEL_CYCLES)
  ) u_door (
    .clk_i       (clock),
    .rst_i       (reset),
    .open_cmd_i  (door_open_cmd),
    .close_cmd_i (door_close_cmd),
    .power_on_i  (power_on),
    .open_allow_i(door_allow),
    .state_o     (door_q)
  );

  assign current_floor   = floor_q;
  assign at_floor_pulse  = pulse_q;
  assign car_moving      = moving_q;
  assign car_direction   = dir_q;
  assign door_state      = door_q;
  assign interlock_fault = fault_q;

endmodule

// File: tb/tb_elevator_car_responder.sv
// Scoreboard bench: a position-based car/door model predicts every cycle's outputs.
module tb_elevator_car_responder;

  localparam int NF  = 11;
  localparam int FTC = 16;
  localparam int DTC = 8;

  logic       clock = 1'b0;
  logic       reset, move_up, move_down, door_open_cmd, door_close_cmd, emergency_stop, power_on;
  logic [3:0] current_floor;
  logic       at_floor_pulse, car_moving, car_direction, interlock_fault;
  logic [1:0] door_state;

  always #5 clock = ~clock;

  elevator_car_responder dut (
    .clock          (clock),
    .reset          (reset),
    .move_up        (move_up),
    .move_down      (move_down),
    .door_open_cmd  (door_open_cmd),
    .door_close_cmd (door_close_cmd),
    .emergency_stop (emergency_stop),
    .power_on       (power_on),
    .current_floor  (current_floor),
    .at_floor_pulse (at_floor_pulse),
    .car_moving     (car_moving),
    .car_direction  (car_direction),
    .door_state     (door_state),
    .interlock_fault(interlock_fault)
  );

  typedef struct {
    int floor;
    int pulse;
    int moving;
    int dir;
    int door;
    int fault;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_passed = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_passed++;
    else $display("FAIL %s at %0t: got %0d, required %0d", name, $time, act, req);
  endtask

  // Model: car position in ticks (floor*FTC + progress), door position 0..DTC with motion sign.
  int m_pos, m_going, m_floor, m_dp, m_dm;
  bit m_halted, m_dir, m_pulse, m_fault;

  task automatic model_step(input bit rst, input bit up, input bit dn, input bit op, input bit cl,
                            input bit es, input bit pw, output exp_t e);
    bit halt, moving, door_closed, door_ok;
    if (rst) begin
      m_pos = 0; m_going = 0; m_floor = 0; m_dp = 0; m_dm = 0;
      m_halted = 0; m_dir = 1; m_pulse = 0; m_fault = 0;
    end else begin
      halt        = es || !pw;
      moving      = (m_going != 0) && !m_halted;
      door_closed = (m_dm == 0) && (m_dp == 0);
      door_ok     = !moving && (m_pos % FTC == 0);
      m_pulse     = 0;
      m_fault     = op && moving;
      if (m_halted) begin
        if (!halt) begin
          m_halted = 0;
          if (!door_closed) m_going = 0;
        end
      end else if (halt) begin
        m_halted = 1;
      end else if (m_going != 0) begin
        m_pos += m_going;
        if (m_pos % FTC == 0) begin
          m_pulse = 1;
          m_floor = m_pos / FTC;
          if (!((m_going > 0) ? (up && m_floor < NF - 1) : (dn && m_floor > 0))) m_going = 0;
        end
      end else if (up || dn) begin
        if ((up && dn) || !door_closed || (up && m_floor == NF - 1) || (dn && m_floor == 0))
          m_fault = 1;
        else if (!op) begin
          m_going = up ? 1 : -1;
          m_dir   = up;
        end
      end
      if (pw) begin
        if (m_dm > 0) begin
          m_dp++;
          if (m_dp == DTC) m_dm = 0;
        end else if (m_dm < 0) begin
          m_dp--;
          if (op) m_dm = 1;
          else if (m_dp == 0) m_dm = 0;
        end else if (m_dp == 0) begin
          if (op && door_ok) m_dm = 1;
        end else if (cl && !op) begin
          m_dm = -1;
        end
      end
    end
    e.floor  = m_floor;
    e.pulse  = m_pulse;
    e.moving = ((m_going != 0) && !m_halted) ? 1 : 0;
    e.dir    = m_dir;
    e.door   = (m_dm > 0) ? 1 : (m_dm < 0) ? 3 : (m_dp == 0) ? 0 : 2;
    e.fault  = m_fault;
  endtask

  task automatic step(input bit rst, input bit up, input bit dn, input bit op, input bit cl,
                      input bit es, input bit pw);
    exp_t e;
    reset = rst; move_up = up; move_down = dn; door_open_cmd = op; door_close_cmd = cl;
    emergency_stop = es; power_on = pw;
    model_step(rst, up, dn, op, cl, es, pw, e);
    @(posedge clock);
    sb_q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 1);
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("current_floor", int'(current_floor), e.floor);
      check("at_floor_pulse", int'(at_floor_pulse), e.pulse);
      check("car_moving", int'(car_moving), e.moving);
      check("car_direction", int'(car_direction), e.dir);
      check("door_state", int'(door_state), e.door);
      check("interlock_fault", int'(interlock_fault), e.fault);
    end
  end

  initial begin
    bit up, dn, es, pw;
    up = 0; dn = 0; es = 0; pw = 1;
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    check("reset_floor", int'(current_floor), 0);
    check("reset_dir", int'(car_direction), 1);
    check("reset_door", int'(door_state), 0);

    // Hold move_up for three floors.
    for (int i = 0; i < 48; i++) begin
      step(0, 1, 0, 0, 0, 0, 1);
      check("s1_pulse", int'(at_floor_pulse), (i == 16 || i == 32) ? 1 : 0);
      check("s1_moving", int'(car_moving), 1);
    end
    step(0, 0, 0, 0, 0, 0, 1);
    check("s1_pulse48", int'(at_floor_pulse), 1);
    check("s1_floor", int'(current_floor), 3);

    // Climb to the top floor, then request up again.
    for (int i = 0; i < 7 * FTC + 1; i++) step(0, 1, 0, 0, 0, 0, 1);
    check("s2_top_floor", int'(current_floor), 10);
    step(0, 1, 0, 0, 0, 0, 1);
    check("s2_fault", int'(interlock_fault), 1);
    check("s2_moving", int'(car_moving), 0);
    idle(1);
    check("s2_fault_once", int'(interlock_fault), 0);
    check("s2_floor", int'(current_floor), 10);

    // Down to floor 2.
    for (int i = 0; i < 8 * FTC; i++) step(0, 0, 1, 0, 0, 0, 1);
    idle(1);
    check("s3_start_floor", int'(current_floor), 2);

    // Drop move_up at count 5: car still completes the floor.
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 0, 1);
    for (int k = 0; k <= 10; k++) begin
      idle(1);
      check("s3_pulse", int'(at_floor_pulse), (k == 10) ? 1 : 0);
    end
    check("s3_floor", int'(current_floor), 3);
    idle(1);
    check("s3_idle", int'(car_moving), 0);

    // Emergency stop at count 7 for 20 cycles.
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0, 0, 1, 1);
      check("s4_halted_moving", int'(car_moving), 0);
    end
    check("s4_frozen_floor", int'(current_floor), 3);
    for (int k = 0; k < 10; k++) begin
      idle(1);
      check("s4_pulse", int'(at_floor_pulse), (k == 9) ? 1 : 0);
    end
    check("s4_floor", int'(current_floor), 4);

    // Door open, close, reverse at closing count 5.
    step(0, 0, 0, 1, 0, 0, 1);
    idle(DTC);
    check("s5_open", int'(door_state), 2);
    step(0, 0, 0, 0, 1, 0, 1);
    idle(5);
    check("s5_closing", int'(door_state), 3);
    step(0, 0, 0, 1, 0, 0, 1);
    check("s5_reversed", int'(door_state), 1);
    for (int k = 0; k < 6; k++) begin
      idle(1);
      check("s5_reopen", int'(door_state), (k == 5) ? 2 : 1);
    end

    // Move requests with the door open.
    step(0, 0, 1, 0, 0, 0, 1);
    check("s6_down_fault", int'(interlock_fault), 1);
    check("s6_down_still", int'(car_moving), 0);
    step(0, 1, 1, 0, 0, 0, 1);
    check("s6_both_fault", int'(interlock_fault), 1);
    check("s6_both_still", int'(car_moving), 0);
    step(0, 0, 0, 0, 1, 0, 1);
    idle(DTC);
    check("s6_closed", int'(door_state), 0);

    // Reset mid-travel.
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 1);
    check("rst_mid_pulse", int'(at_floor_pulse), 0);
    check("rst_mid_floor", int'(current_floor), 0);

    // Randomised traffic.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 99) < 4) up = !up;
      if ($urandom_range(0, 99) < 3) dn = !dn;
      if (es) es = ($urandom_range(0, 99) >= 10);
      else    es = ($urandom_range(0, 999) < 5);
      if (!pw) pw = ($urandom_range(0, 99) < 15);
      else     pw = ($urandom_range(0, 999) >= 3);
      step(($urandom_range(0, 1999) == 0), up, dn, ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 99) < 5), es, pw);
    end

    @(negedge clock);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
